// File: rtl/mux_arb_reg.sv
// Registered N-channel valid/ready mux with select or round-robin arbitration.
// Optional even parity output enabled by MUX_ARB_PARITY_EN.
module mux_arb_reg #(
  parameter int NCH  = 3,
  parameter int W    = 2,
  parameter int SELW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  input  logic [NCH-1:0]    in_valid,
  input  logic [NCH*W-1:0]  in_data,
  output logic [NCH-1:0]    in_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [SELW-1:0]   out_ch,
  input  logic              out_ready,
`ifdef MUX_ARB_PARITY_EN
  output logic              out_par,
`endif
  output logic              sel_err
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    data_q, data_d;
  logic [SELW-1:0] ch_q, ch_d;
  logic [SELW-1:0] rr_q, rr_d;
  logic            err_q, err_d;
  logic            load;
  logic            hit;
  logic [SELW-1:0] gnt;
  logic [W-1:0]    gnt_data;

`ifdef MUX_ARB_PARITY_EN
  logic par_q, par_d;
`endif

  // Pick the candidate channel: explicit select or round-robin search
  always_comb begin
    int idx;
    idx = 0;
    hit = 1'b0;
    gnt = '0;
    if (!mode) begin
      if (int'(sel) < NCH) begin
        if (in_valid[sel]) begin
          hit = 1'b1;
          gnt = sel;
        end
      end
    end else begin
      // Descending walk: the last hit is the first in search order
      for (int k = NCH; k >= 1; k--) begin
        idx = (int'(rr_q) + k) % NCH;
        if (in_valid[idx]) begin
          hit = 1'b1;
          gnt = SELW'(idx);
        end
      end
    end
    gnt_data = in_data[int'(gnt)*W +: W];
  end

  // Next-state, accept strobes and output register updates
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    ch_d     = ch_q;
    rr_d     = rr_q;
    err_d    = 1'b0;
    in_ready = '0;
`ifdef MUX_ARB_PARITY_EN
    par_d    = par_q;
`endif
    load = (state_q == EMPTY) || out_ready;
    if (load) begin
      err_d = !mode && (int'(sel) >= NCH);
      if (hit) begin
        in_ready[gnt] = !rst;
        data_d  = gnt_data;
        ch_d    = gnt;
        state_d = FULL;
        if (mode) begin
          rr_d = gnt;
        end
`ifdef MUX_ARB_PARITY_EN
        par_d = ^{gnt, gnt_data};
`endif
      end else begin
        state_d = EMPTY;
        data_d  = '0;
`ifdef MUX_ARB_PARITY_EN
        par_d   = 1'b0;
`endif
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      ch_q    <= '0;
      rr_q    <= SELW'(NCH - 1);
      err_q   <= 1'b0;
`ifdef MUX_ARB_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
`ifdef MUX_ARB_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign sel_err   = err_q;
`ifdef MUX_ARB_PARITY_EN
  assign out_par   = par_q;
`endif

endmodule

// File: doc/mux_arb_reg.md
Name: mux_arb_reg

Overview:
- Parametrised, registered successor to the small 2-bit select mux: N channels of W-bit data merged onto one output.
- Each input channel and the output use a valid/ready handshake.
- Channel choice comes from an explicit select input (legacy mode) or from internal round-robin arbitration.
- Sits between the per-channel encoders and the Tx data path; replaces the fixed 3-input combinational mux.

Parameters:
- NCH, 3, number of input channels (2..16).
- W, 2, data width per channel (1..64).
- SELW, 2, select/channel-index width; must satisfy 2^SELW >= NCH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = explicit select, 1 = round-robin arbitration.
- sel  input  SELW  channel index used in mode 0.
- in_valid  input  NCH  per-channel data valid.
- in_data  input  NCH*W  channel i occupies bits [i*W +: W].
- in_ready  output  NCH  per-channel accept, one-hot or zero.
- out_valid  output  1  output register holds data.
- out_data  output  W  registered data; forced 0 when out_valid=0.
- out_ch  output  SELW  index of the channel that supplied out_data.
- out_ready  input  1  downstream accept.
- sel_err  output  1  registered one-cycle pulse: mode 0 with sel >= NCH.

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_data=0, out_ch=0, sel_err=0, rr_ptr=NCH-1 (so channel 0 wins first). in_ready is combinational and is 0 while rst=1.
- State machine:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- load = (EMPTY) or (FULL and out_ready).
- Candidate:
  - Mode 0: sel, if sel < NCH and in_valid[sel]=1.
  - Mode 1: first i with in_valid[i]=1, searching (rr_ptr+1) mod NCH upward with wrap-around.
- in_ready[g] = load and candidate g exists; all other bits are 0.
- On a clk edge with load=1 and a candidate g:
  - out_data <= in_data[g], out_ch <= g, state -> FULL.
  - Mode 1 only: rr_ptr <= g.
- On load=1 with no candidate: state -> EMPTY, out_data <= 0. out_ch holds its value.
- FULL and out_ready=0: all outputs hold; in_ready=0.
- Latency and throughput:
  - Input accept to out_valid is 1 cycle.
  - Full throughput: a simultaneous drain and reload happens in the same cycle, with no bubble.
- Mode 0, sel >= NCH:
  - No channel is selected (equivalent of the old default out=0).
  - sel_err=1 in the following cycle, then 0.
- mode or sel changes while FULL: the held word is unaffected. The new value applies at the next load.
- mode 0 leaves rr_ptr unchanged. Switching to mode 1 resumes from the stored rr_ptr.
- Single requester in mode 1: the same channel is granted every load cycle.
- All requesters active in mode 1: grants rotate 0,1,...,NCH-1,0.
- rst asserted while FULL: the data word is discarded and out_valid drops in the next cycle. Reset has priority over load.
- Upstream is required to hold in_data stable while in_valid=1 and in_ready=0. The block does not check this.

Optional Feature:
- Macro: MUX_ARB_PARITY_EN.
- Defined:
  - Extra output out_par (1 bit), registered alongside out_data.
  - out_par = even parity over {out_ch, out_data}.
  - out_par resets to 0 and is 0 when out_valid=0.
- Undefined: port out_par absent; no parity logic.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then mode=0, sel=1, in_valid=3'b011, in_data={2'b00,2'b10,2'b01}, out_ready=1 -> next cycle out_valid=1, out_data=2'b10, out_ch=1, in_ready=3'b010 on the accepting cycle.
- Mode=0, sel=3 (NCH=3), in_valid=3'b111 -> in_ready=0, out_valid=0, out_data=0, sel_err=1 for exactly one cycle.
- Mode=1, in_valid=3'b111 held, out_ready=1 for 6 cycles -> out_ch sequence 0,1,2,0,1,2, out_valid continuously 1 after the first cycle.
- Mode=1, output FULL with out_ch=0, out_ready=0 for 3 cycles -> out_data/out_ch stable, in_ready=0. Then out_ready=1 -> next grant is channel 1 in the same cycle (no bubble).
- Rst asserted for 1 cycle while FULL in mode 1 after grant 1 -> out_valid=0 next cycle; with in_valid=3'b111, the first grant after reset is channel 0.
- MUX_ARB_PARITY_EN defined: grant ch2 with data 2'b11 -> out_par = ^{2'b10,2'b11} = 1; when out_valid=0, out_par=0.
